m_seq_chk: RTL and testbench
============================

// Module: m_seq_chk
// PURPOSE
//  Serial checker for the 4-bit m-sequence (x^4+x^3+1, period 15) produced by the upstream m-sequence generator.
//  Consumes that generator's 1-bit output stream, self-synchronises to it, then flywheels, flagging and counting bit errors.
//  Sits directly downstream of the generator; feeds lock/error status to the test/monitor logic.
//  Recurrence checked: s[n] = s[n-1] ^ s[n-4]; from generator seed 1111 the stream is 111101011001000, repeating.
// PARAMETERS
//  LOCK_CNT  8   consecutive correct predictions (after 4-bit fill) required to enter LOCK; range 1..15
//  LOSS_ERR  3   errors within one 15-bit window that drop LOCK; range 1..15
//  ERR_W     8   width of saturating error counter
// PORTS
//  clk      in   1      clock, all state updates on posedge
//  res      in   1      reset, asynchronous, active-high
//  en       in   1      din valid this cycle; when low, no state changes except clr
//  din      in   1      serial m-sequence bit from generator
//  clr      in   1      synchronous clear of err_cnt
//  lock     out  1      1 = checker synchronised (LOCK state)
//  err      out  1      one-cycle pulse: mismatch detected in LOCK
//  err_cnt  out  ERR_W  saturating count of LOCK-state mismatches
// BEHAVIOUR
//  Reset (async, res=1): state=FILL, sr=0, all counters 0, lock=0, err=0, err_cnt=0. Takes effect immediately, mid-operation included.
//  sr[3:0]: history, sr[3] newest sample. Prediction: pred = sr[3] ^ sr[0]. Shift: sr <= {bit, sr[3:1]}.
//  FILL: each en cycle shifts din into sr; after 4th sample -> SYNC, good_cnt=0.
//  SYNC: each en cycle: match = (din==pred) && (sr!=4'b0000). Shift din into sr.
//    match: good_cnt+1; if it reaches LOCK_CNT -> LOCK, win_pos=0, win_err=0.
//    mismatch: good_cnt=0, stay SYNC (history already holds received bits; no refill).
//  All-zero history is never a match: stuck-at-0 input must never lock.
//  LOCK: each en cycle, sr shifts in pred (flywheel), NOT din, so one flipped bit counts exactly once.
//    din!=pred: err=1 next cycle, err_cnt+1 (saturates at 2^ERR_W-1), win_err+1.
//    win_pos counts 0..14 then wraps and clears win_err; an error on the wrap cycle counts to the closing window first.
//    win_err reaching LOSS_ERR -> FILL, sr=0, good_cnt=0, lock=0. err_cnt is preserved.
//  Outputs registered: lock rises the cycle after the LOCK_CNT-th match sample; err is high exactly one cycle after the offending sample.
//  en=0: err deasserts, everything else holds.
//  clr=1: err_cnt <= 0, priority over a same-cycle increment; err pulse is still generated.
//  Latency from clean stream start: 4+LOCK_CNT en-cycles to lock (12 at default).
// STRUCTURE
//  Package m_seq_pkg: state encodings (FILL/SYNC/LOCK), SEQ_LEN=15, SEQ_W=4, tap positions, generator seed 4'b1111.
//  Sub-module m_seq_pred: 4-bit history register and pred/all-zero logic, with select input din vs pred.
//  Top holds FSM, good_cnt, win_pos/win_err, err_cnt.
// TESTING (bench drives din from the m-sequence generator, its reset = ~res; en=1 unless stated)
//  1 Clean stream, 300 cycles -> lock=1 from cycle 13 after first sample, err never 1, err_cnt=0.
//  2 After lock, invert one din bit -> err high exactly 1 cycle, err_cnt=1, lock stays 1, no further errors.
//  3 After lock, invert 3 bits within 15 samples -> lock=0 the cycle after 3rd error, err_cnt=3; clean stream relocks after 12 samples.
//  4 din held 0 for 100 cycles, then held 1 for 100 cycles -> lock never asserts; err_cnt=0.
//  5 en toggling 1/0 each cycle on a clean stream (generator clock-enabled identically) -> lock after 12 enabled samples, err_cnt=0.
//  6 res pulse mid-LOCK -> lock=0, err_cnt=0 with no clock edge. Separately, clr coincident with an error -> err=1 and err_cnt=0. ERR_W=2 with LOSS_ERR=15: 5 isolated errors -> err_cnt=3.

Source files
------------

// File: rtl/m_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : m_seq_pkg
//  Purpose  : Shared constants and state encoding for the 4-bit m-sequence
//             (x^4+x^3+1, period 15) checker.
//  Revision : 1.0  initial release
// ============================================================================
package m_seq_pkg;

  localparam int SEQ_LEN = 15;  // sequence period
  localparam int SEQ_W   = 4;   // history / generator width

  // Tap positions in the history register (index 3 holds the newest sample)
  localparam int TAP_NEW = 3;   // s[n-1]
  localparam int TAP_OLD = 0;   // s[n-4]

  localparam logic [SEQ_W-1:0] GEN_SEED = 4'b1111;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_SYNC = 2'd1,
    ST_LOCK = 2'd2
  } state_t;

endpackage : m_seq_pkg
`default_nettype wire

// File: rtl/m_seq_pred.sv
`default_nettype none
// ============================================================================
//  Module   : m_seq_pred
//  Purpose  : 4-bit history register with next-bit prediction.
//  Ports    : clk, rst       clock, async active-high reset
//             i_shift        shift one bit into the history
//             i_clear        zero the history (wins over i_shift)
//             i_sel_pred     1 = shift in own prediction, 0 = shift in i_din
//             i_din          received bit
//             o_pred         predicted next bit s[n-1]^s[n-4]
//             o_zero         history is all-zero (prediction meaningless)
//  Revision : 1.0  initial release
// ============================================================================
module m_seq_pred
  import m_seq_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_shift,
  input  logic i_clear,
  input  logic i_sel_pred,
  input  logic i_din,
  output logic o_pred,
  output logic o_zero
);

  logic [SEQ_W-1:0] r_sr;
  logic             w_pred;
  logic             w_bit;

  assign w_pred = r_sr[TAP_NEW] ^ r_sr[TAP_OLD];
  assign w_bit  = i_sel_pred ? w_pred : i_din;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sr <= '0;
    end else if (i_clear) begin
      r_sr <= '0;
    end else if (i_shift) begin
      r_sr <= {w_bit, r_sr[SEQ_W-1:1]};
    end
  end

  assign o_pred = w_pred;
  assign o_zero = (r_sr == '0);

endmodule : m_seq_pred
`default_nettype wire

// File: rtl/m_seq_chk.sv
`default_nettype none
// ============================================================================
//  Module   : m_seq_chk
//  Purpose  : Self-synchronising checker for the x^4+x^3+1 m-sequence.
//             Fills history, syncs on LOCK_CNT correct predictions, then
//             flywheels on its own prediction, flagging and counting errors.
//  Ports    : clk      clock
//             res      async active-high reset
//             en       din valid this cycle
//             din      serial m-sequence bit
//             clr      synchronous clear of err_cnt
//             lock     checker synchronised
//             err      one-cycle pulse per mismatch while locked
//             err_cnt  saturating mismatch count
//  Revision : 1.0  initial release
// ============================================================================
module m_seq_chk
  import m_seq_pkg::*;
#(
  parameter int LOCK_CNT = 8,
  parameter int LOSS_ERR = 3,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             res,
  input  logic             en,
  input  logic             din,
  input  logic             clr,
  output logic             lock,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt
);

  localparam logic [3:0] c_FILL_LAST = 4'(SEQ_W - 1);
  localparam logic [3:0] c_LOCK_LAST = 4'(LOCK_CNT - 1);
  localparam logic [3:0] c_WIN_LAST  = 4'(SEQ_LEN - 1);
  localparam logic [3:0] c_LOSS      = 4'(LOSS_ERR);

  state_t           r_state, w_state_nxt;
  logic [3:0]       r_good_cnt, w_good_nxt;   // also counts fill samples
  logic [3:0]       r_win_pos, w_pos_nxt;
  logic [3:0]       r_win_err, w_werr_nxt;
  logic [3:0]       w_werr_sum;
  logic             r_lock, r_err;
  logic [ERR_W-1:0] r_err_cnt;

  logic w_shift, w_sr_clr, w_sel_pred, w_mis_lock;
  logic w_pred, w_zero, w_match;

  m_seq_pred u_pred (
    .clk        (clk),
    .rst        (res),
    .i_shift    (w_shift),
    .i_clear    (w_sr_clr),
    .i_sel_pred (w_sel_pred),
    .i_din      (din),
    .o_pred     (w_pred),
    .o_zero     (w_zero)
  );

  // An all-zero history predicts 0 forever; never count it as a match so a
  // stuck-at-0 line cannot lock.
  assign w_match    = (din == w_pred) && !w_zero;
  assign w_werr_sum = r_win_err + 4'(w_mis_lock);

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_state    <= ST_FILL;
      r_good_cnt <= '0;
      r_win_pos  <= '0;
      r_win_err  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_good_cnt <= w_good_nxt;
      r_win_pos  <= w_pos_nxt;
      r_win_err  <= w_werr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good_cnt;
    w_pos_nxt   = r_win_pos;
    w_werr_nxt  = r_win_err;
    w_shift     = 1'b0;
    w_sr_clr    = 1'b0;
    w_sel_pred  = 1'b0;
    w_mis_lock  = 1'b0;
    if (en) begin
      case (r_state)
        ST_FILL: begin
          w_shift = 1'b1;
          if (r_good_cnt == c_FILL_LAST) begin
            w_state_nxt = ST_SYNC;
            w_good_nxt  = '0;
          end else begin
            w_good_nxt  = r_good_cnt + 4'd1;
          end
        end
        ST_SYNC: begin
          // History keeps the received bits on a mismatch, so no refill.
          w_shift = 1'b1;
          if (w_match) begin
            if (r_good_cnt == c_LOCK_LAST) begin
              w_state_nxt = ST_LOCK;
              w_good_nxt  = '0;
              w_pos_nxt   = '0;
              w_werr_nxt  = '0;
            end else begin
              w_good_nxt  = r_good_cnt + 4'd1;
            end
          end else begin
            w_good_nxt = '0;
          end
        end
        ST_LOCK: begin
          // Flywheel: feed back the prediction so a flipped bit counts once.
          w_shift    = 1'b1;
          w_sel_pred = 1'b1;
          w_mis_lock = (din != w_pred);
          // The error on the wrap cycle belongs to the closing window.
          if (w_werr_sum >= c_LOSS) begin
            w_state_nxt = ST_FILL;
            w_sr_clr    = 1'b1;
            w_good_nxt  = '0;
          end else if (r_win_pos == c_WIN_LAST) begin
            w_pos_nxt  = '0;
            w_werr_nxt = '0;
          end else begin
            w_pos_nxt  = r_win_pos + 4'd1;
            w_werr_nxt = w_werr_sum;
          end
        end
        default: begin
          w_state_nxt = ST_FILL;
          w_sr_clr    = 1'b1;
          w_good_nxt  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_lock    <= 1'b0;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_lock <= (w_state_nxt == ST_LOCK);
      r_err  <= w_mis_lock;
      if (clr) begin
        r_err_cnt <= '0;
      end else if (w_mis_lock && (r_err_cnt != {ERR_W{1'b1}})) begin
        r_err_cnt <= r_err_cnt + 1'b1;
      end
    end
  end

  assign lock    = r_lock;
  assign err     = r_err;
  assign err_cnt = r_err_cnt;

endmodule : m_seq_chk
`default_nettype wire

// File: tb/tb_m_seq_chk.sv
`default_nettype none
// ============================================================================
//  Module   : tb_m_seq_chk
//  Purpose  : Directed self-checking bench for m_seq_chk. Drives the
//             period-15 stream 111101011001000 (seed 1111) with optional
//             bit inversion; a second instance uses ERR_W=2, LOSS_ERR=15.
//  Revision : 1.0  initial release
// ============================================================================
module tb_m_seq_chk;

  logic       clk = 1'b0;
  logic       res, en, din, clr;
  logic       lock, err;
  logic [7:0] err_cnt;
  logic       lock2, err2;
  logic [1:0] err_cnt2;

  int n_checks = 0;
  int n_errors = 0;

  logic [14:0] seq_v;
  int          gpos;
  logic        any_err, any_lock;

  always #5 clk = ~clk;

  m_seq_chk dut (
    .clk(clk), .res(res), .en(en), .din(din), .clr(clr),
    .lock(lock), .err(err), .err_cnt(err_cnt)
  );

  m_seq_chk #(.LOCK_CNT(8), .LOSS_ERR(15), .ERR_W(2)) dut2 (
    .clk(clk), .res(res), .en(en), .din(din), .clr(clr),
    .lock(lock2), .err(err2), .err_cnt(err_cnt2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One sample: generator bit (optionally inverted) presented for one edge;
  // outputs are stable when this returns.
  task automatic drive(input logic e, input logic flip);
    en  = e;
    din = seq_v[14 - gpos] ^ flip;
    @(posedge clk);
    #1;
    if (e) gpos = (gpos == 14) ? 0 : gpos + 1;
    any_err  = any_err | err;
    any_lock = any_lock | lock;
  endtask

  task automatic drive_raw(input logic d);
    en  = 1'b1;
    din = d;
    @(posedge clk);
    #1;
    any_err  = any_err | err;
    any_lock = any_lock | lock;
  endtask

  // Reset pulse placed between clock edges; generator restarts from its seed.
  task automatic pulse_reset();
    #2 res = 1'b1;
    #1 res = 1'b0;
    gpos = 0;
  endtask

  initial begin
    seq_v = 15'b111101011001000;
    gpos  = 0;
    res = 1'b1; en = 1'b0; din = 1'b0; clr = 1'b0;
    any_err = 1'b0; any_lock = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_lock", lock, 0);
    check("rst_err", err, 0);
    check("rst_cnt", err_cnt, 0);
    res = 1'b0;

    // 1: clean stream
    for (int i = 1; i <= 300; i++) begin
      drive(1'b1, 1'b0);
      if (i == 11) check("t1_lock_s11", lock, 0);
      if (i == 12) check("t1_lock_s12", lock, 1);
    end
    check("t1_lock_end", lock, 1);
    check("t1_no_err", any_err, 0);
    check("t1_cnt", err_cnt, 0);

    // 2: single inverted bit
    drive(1'b1, 1'b1);
    check("t2_err", err, 1);
    check("t2_cnt", err_cnt, 1);
    check("t2_lock", lock, 1);
    drive(1'b1, 1'b0);
    check("t2_err_gone", err, 0);
    any_err = 1'b0;
    repeat (30) drive(1'b1, 1'b0);
    check("t2_no_more", any_err, 0);
    check("t2_cnt_end", err_cnt, 1);
    check("t2_lock_end", lock, 1);

    // 3: three errors inside one window drop lock, then relock
    clr = 1'b1;
    drive(1'b1, 1'b0);
    clr = 1'b0;
    check("t3_clr", err_cnt, 0);
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b0);
    check("t3_lock_2err", lock, 1);
    drive(1'b1, 1'b1);
    check("t3_unlock", lock, 0);
    check("t3_err", err, 1);
    check("t3_cnt", err_cnt, 3);
    for (int i = 1; i <= 12; i++) begin
      drive(1'b1, 1'b0);
      if (i == 11) check("t3_relock_s11", lock, 0);
      if (i == 12) check("t3_relock_s12", lock, 1);
    end
    check("t3_cnt_kept", err_cnt, 3);

    // 4: stuck-at-0 then stuck-at-1 never locks
    pulse_reset();
    any_lock = 1'b0;
    any_err  = 1'b0;
    repeat (100) drive_raw(1'b0);
    repeat (100) drive_raw(1'b1);
    check("t4_never_lock", any_lock, 0);
    check("t4_no_err", any_err, 0);
    check("t4_cnt", err_cnt, 0);

    // 5: en toggling, generator advances only on enabled cycles
    pulse_reset();
    for (int i = 1; i <= 12; i++) begin
      drive(1'b1, 1'b0);
      if (i == 11) check("t5_lock_s11", lock, 0);
      if (i == 12) check("t5_lock_s12", lock, 1);
      drive(1'b0, 1'b0);
      if (i == 12) check("t5_lock_hold", lock, 1);
    end
    check("t5_cnt", err_cnt, 0);

    // 6a: async reset mid-LOCK with a non-zero count
    drive(1'b1, 1'b1);
    check("t6_pre_cnt", err_cnt, 1);
    #2 res = 1'b1;
    #1;
    check("t6_rst_lock", lock, 0);
    check("t6_rst_cnt", err_cnt, 0);
    check("t6_rst_err", err, 0);
    #1 res = 1'b0;
    gpos = 0;

    // 6b: clr coincident with an error
    repeat (12) drive(1'b1, 1'b0);
    check("t6_relock", lock, 1);
    clr = 1'b1;
    drive(1'b1, 1'b1);
    clr = 1'b0;
    check("t6_clr_err", err, 1);
    check("t6_clr_cnt", err_cnt, 0);

    // 6c: five isolated errors; narrow counter saturates
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b1);
      repeat (20) drive(1'b1, 1'b0);
    end
    check("t6_cnt5", err_cnt, 5);
    check("t6_sat_cnt", err_cnt2, 3);
    check("t6_lock1", lock, 1);
    check("t6_lock2", lock2, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_m_seq_chk
`default_nettype wire
